// File: rtl/score_argmax.sv
// -----------------------------------------------------------------------------
// score_argmax
//   Classification stage fed by the neuron-score adder. Tracks the running
//   maximum of NUM_CLASSES signed scores per frame and publishes the winning
//   class index and its score once per completed frame.
//
//   Ports:
//     clk          in   single clock, rising edge
//     GlobalReset  in   synchronous, active-low reset
//     Score_In     in   signed score for the current class
//     Score_Valid  in   Score_In valid this cycle (always accepted)
//     Frame_Clear  in   synchronous abort of the partial frame
//     Class_Out    out  index of the maximum score of the last frame
//     Max_Score    out  maximum score of the last frame
//     Class_Valid  out  one-cycle pulse when Class_Out/Max_Score update
//     Busy         out  high while a frame is partially received
//
//   Optional build macro:
//     ARGMAX_INPUT_REG_EN  registers Score_In/Score_Valid/Frame_Clear once
//                          before the core (adds one cycle to all latencies)
// -----------------------------------------------------------------------------
module score_argmax #(
    parameter int DATA_W      = 26,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic                     clk,
    input  logic                     GlobalReset,
    input  logic signed [DATA_W-1:0] Score_In,
    input  logic                     Score_Valid,
    input  logic                     Frame_Clear,
    output logic        [IDX_W-1:0]  Class_Out,
    output logic signed [DATA_W-1:0] Max_Score,
    output logic                     Class_Valid,
    output logic                     Busy
);

    typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic signed [DATA_W-1:0] w_score;
    logic                     w_vld;
    logic                     w_clr;

    // ---- input stage (p0) ----
`ifdef ARGMAX_INPUT_REG_EN
    logic signed [DATA_W-1:0] r_score_p0;
    logic                     r_vld_p0;
    logic                     r_clr_p0;

    // Clear travels with the data so clear/valid ordering is preserved.
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            r_score_p0 <= '0;
            r_vld_p0   <= 1'b0;
            r_clr_p0   <= 1'b0;
        end else begin
            r_score_p0 <= Score_In;
            r_vld_p0   <= Score_Valid;
            r_clr_p0   <= Frame_Clear;
        end
    end

    assign w_score = r_score_p0;
    assign w_vld   = r_vld_p0;
    assign w_clr   = r_clr_p0;
`else
    assign w_score = Score_In;
    assign w_vld   = Score_Valid;
    assign w_clr   = Frame_Clear;
`endif

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic        [IDX_W-1:0]  r_cnt;
    logic        [IDX_W-1:0]  w_cnt_nxt;
    logic signed [DATA_W-1:0] r_best_score;
    logic        [IDX_W-1:0]  r_best_idx;
    logic        [IDX_W-1:0]  r_class_out;
    logic signed [DATA_W-1:0] r_max_score;
    logic                     r_class_valid;

    logic                     w_first;
    logic                     w_gt;
    logic                     w_last;
    logic signed [DATA_W-1:0] w_cand_score;
    logic        [IDX_W-1:0]  w_cand_idx;
    logic                     w_emit;

    // ---- compare stage (core) ----
    // The first score of a frame loads unconditionally; later scores replace
    // only on a strict signed greater-than, so ties keep the lower index.
    always_comb begin
        w_first      = (r_state == S_IDLE);
        w_gt         = (w_score > r_best_score);
        w_cand_score = r_best_score;
        w_cand_idx   = r_best_idx;
        if (w_first) begin
            w_cand_score = w_score;
            w_cand_idx   = '0;
        end else if (w_gt) begin
            w_cand_score = w_score;
            w_cand_idx   = r_cnt;
        end
        // With a single class the state never leaves IDLE: every score ends a frame.
        w_last = (NUM_CLASSES == 1) ? 1'b1 : (!w_first && (r_cnt == LAST_IDX));
    end

    // Next-state logic: clear dominates a coincident valid score.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_clr) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_vld) begin
            if (w_last) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = S_ACCUM;
                w_cnt_nxt   = r_cnt + 1'b1;
            end
        end
    end

    // Output decode.
    always_comb begin
        w_emit      = w_vld && !w_clr && w_last;
        Class_Out   = r_class_out;
        Max_Score   = r_max_score;
        Class_Valid = r_class_valid;
        Busy        = (r_state == S_ACCUM);
    end

    // ---- result stage ----
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_best_score  <= '0;
            r_best_idx    <= '0;
            r_class_out   <= '0;
            r_max_score   <= '0;
            r_class_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_class_valid <= w_emit;
            if (w_vld && !w_clr) begin
                r_best_score <= w_cand_score;
                r_best_idx   <= w_cand_idx;
            end
            if (w_emit) begin
                r_class_out <= w_cand_idx;
                r_max_score <= w_cand_score;
            end
        end
    end

endmodule

// File: tb/tb_score_argmax.sv
// -----------------------------------------------------------------------------
// tb_score_argmax
//   Scoreboard bench for score_argmax: a reference model runs at drive time
//   and queues the expected (index, score, cycle) of each completed frame;
//   a negedge monitor pops and compares whenever Class_Valid is seen.
// -----------------------------------------------------------------------------
module tb_score_argmax;

    localparam int DATA_W = 26;
    localparam int NC     = 10;
    localparam int IDX_W  = 4;
`ifdef ARGMAX_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                     clk = 1'b0;
    logic                     GlobalReset = 1'b0;
    logic signed [DATA_W-1:0] Score_In = '0;
    logic                     Score_Valid = 1'b0;
    logic                     Frame_Clear = 1'b0;
    logic        [IDX_W-1:0]  Class_Out;
    logic signed [DATA_W-1:0] Max_Score;
    logic                     Class_Valid;
    logic                     Busy;

    score_argmax #(.DATA_W(DATA_W), .NUM_CLASSES(NC), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .Score_In    (Score_In),
        .Score_Valid (Score_Valid),
        .Frame_Clear (Frame_Clear),
        .Class_Out   (Class_Out),
        .Max_Score   (Max_Score),
        .Class_Valid (Class_Valid),
        .Busy        (Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int score;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state.
    int m_cnt  = 0;
    int m_best = 0;
    int m_idx  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Drive one cycle of inputs and advance the model as the core will see it.
    task automatic drv(input bit v, input bit c, input int s);
        exp_t e;
        @(posedge clk);
        #1;
        Score_Valid = v;
        Frame_Clear = c;
        Score_In    = DATA_W'(s);
        if (c) begin
            m_cnt = 0;
        end else if (v) begin
            if (m_cnt == 0) begin
                m_best = s;
                m_idx  = 0;
            end else if (s > m_best) begin
                m_best = s;
                m_idx  = m_cnt;
            end
            m_cnt++;
            if (m_cnt == NC) begin
                e.idx   = m_idx;
                e.score = m_best;
                e.cyc   = cyc + LAT;
                q.push_back(e);
                m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        GlobalReset = 1'b0;
        Score_Valid = 1'b0;
        Frame_Clear = 1'b0;
        Score_In    = '0;
        m_cnt       = 0;
        repeat (2) @(posedge clk);
        #1;
        GlobalReset = 1'b1;
        @(negedge clk);
        chk({tag, "_class_out"},   Class_Out, 0);
        chk({tag, "_max_score"},   Max_Score, 0);
        chk({tag, "_class_valid"}, Class_Valid, 0);
        chk({tag, "_busy"},        Busy, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (GlobalReset && Class_Valid) begin
            if (q.size() == 0) begin
                chk("spurious_pulse", 1, 0);
            end else begin
                e = q.pop_front();
                chk("class_out", Class_Out, e.idx);
                chk("max_score", Max_Score, e.score);
                chk("latency",   cyc,       e.cyc);
            end
        end
    end

    int s1[NC] = '{5, -3, 40, 12, 40, 0, -100, 7, 39, 1};
    int s2[NC] = '{-500, -20, -300, -21, -20, -900, -1000, -50, -60, -70};
    int s5[NC] = '{1, 2, 3, 4, 5, 6, 7, 100, 8, 9};

    initial begin
        do_reset("rst0");

        // Tie-break keeps index 2 over index 4.
        for (int i = 0; i < NC; i++) drv(1'b1, 1'b0, s1[i]);
        idle(4);

        // All negative: signed compare.
        for (int i = 0; i < NC; i++) drv(1'b1, 1'b0, s2[i]);
        idle(4);

        // Ascending with random gaps, then descending back-to-back.
        for (int i = 0; i < NC; i++) begin
            drv(1'b1, 1'b0, i);
            idle($urandom_range(0, 3));
        end
        for (int i = NC - 1; i >= 0; i--) drv(1'b1, 1'b0, i);
        idle(4);

        // Partial frame, then clear with a coincident large score.
        for (int i = 0; i < 4; i++) drv(1'b1, 1'b0, 50 + i);
        idle(2);
        @(negedge clk);
        chk("busy_mid_frame", Busy, 1);
        drv(1'b1, 1'b1, 1000);
        idle(3);
        @(negedge clk);
        chk("busy_after_clear", Busy, 0);
        for (int i = 0; i < NC; i++) drv(1'b1, 1'b0, 3);
        idle(4);

        // Reset mid-frame, then a fresh frame.
        for (int i = 0; i < 6; i++) drv(1'b1, 1'b0, 200 + i);
        do_reset("rst_mid");
        for (int i = 0; i < NC; i++) drv(1'b1, 1'b0, s5[i]);
        idle(10);

        @(negedge clk);
        chk("sb_empty", q.size(), 0);
        chk("busy_end", Busy, 0);
        chk("valid_end", Class_Valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/score_argmax.md
# score_argmax

Classification stage placed directly downstream of `Adder_5Stage`. It consumes the stream of signed 26-bit neuron scores (weighted pixel sum plus `Beta`), one score per neuron, for `NUM_CLASSES` neurons per image. It tracks the running maximum and emits the winning class index and its score once per frame. A frame is a complete image; the winner is the recognised digit for that image.

## Interface
Parameters:
- `DATA_W`, default 26: score width, two's-complement signed.
- `NUM_CLASSES`, default 10: scores per frame.
- `IDX_W`, default 4: class index width; must satisfy 2^IDX_W >= NUM_CLASSES.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `GlobalReset` in 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `Score_In` in DATA_W: signed score for the current class, matching the `Result_1` format.
- `Score_Valid` in 1: `Score_In` is valid this cycle; the block always accepts it (no backpressure).
- `Frame_Clear` in 1: synchronous abort; discards the partial frame.
- `Class_Out` out IDX_W: index of the maximum score in the last completed frame.
- `Max_Score` out DATA_W: the maximum score of the last completed frame.
- `Class_Valid` out 1: one-cycle pulse; `Class_Out` and `Max_Score` are updated this cycle.
- `Busy` out 1: high while a frame is partially received (count between 1 and NUM_CLASSES-1).

## Operation
- Internal state: class counter `cnt` (IDX_W bits), running max `best_score`, running index `best_idx`.
- States: IDLE (cnt=0) and ACCUM (cnt between 1 and NUM_CLASSES-1).
  - IDLE + valid: load `best_score`=Score_In, `best_idx`=0, set cnt=1, go to ACCUM.
  - ACCUM + valid with cnt < NUM_CLASSES-1: compare, then increment cnt.
  - ACCUM + valid with cnt = NUM_CLASSES-1: final compare; register results to the outputs; cnt wraps to 0; go to IDLE.
- Compare rule: signed comparison. Replace only if Score_In > `best_score` strictly. On ties the lower index wins.
- Final cycle: the outputs take the post-compare values, i.e. the final score is included in the result.
- Cycles with Score_Valid low change no state. Gaps of any length between scores are legal.
- Frame_Clear high: cnt=0, state goes to IDLE. Outputs and `Class_Valid` are unaffected.
- Frame_Clear and Score_Valid in the same cycle: clear wins and the score is discarded.
- Frame_Clear on the final-score cycle: no `Class_Valid` pulse is produced.
- NUM_CLASSES=1: every valid score completes a frame, with `Class_Out`=0.
- Outputs hold their values between frames.

## Timing
- Reset values (GlobalReset=0 at a rising edge): `Class_Out`=0, `Max_Score`=0, `Class_Valid`=0, `Busy`=0. Internal state: cnt=0, best_score=0, best_idx=0.
- Reset mid-frame: the partial frame is discarded and no pulse is produced.
- Latency: `Class_Valid` rises in the cycle after the edge that samples the NUM_CLASSES-th valid score. It is registered and lasts exactly one cycle.
- Back-to-back frames are supported. The first score of frame N+1 may be presented in the same cycle that `Class_Valid` for frame N is high.
- Maximum throughput is one score per cycle, i.e. one result every NUM_CLASSES cycles.
- `Busy` is registered and follows cnt with no extra delay.

## Configuration
- Macro: `ARGMAX_INPUT_REG_EN`.
- Defined: `Score_In`, `Score_Valid` and `Frame_Clear` pass through one register stage, reset to 0 by GlobalReset, before the core logic.
  - All latencies grow by one cycle; `Class_Valid` comes two cycles after the final score is presented.
  - Frame_Clear is delayed in step with the data, so clear/valid ordering is preserved.
- Undefined: inputs feed the core directly, with the latency given in Timing.

## Test plan
- Reset then ten scores 5, -3, 40, 12, 40, 0, -100, 7, 39, 1, back-to-back → one-cycle `Class_Valid`; `Class_Out`=2, `Max_Score`=40 (tie-break keeps the lower index).
- All ten scores negative: -500, -20, -300, -21, -20, -900, -1000, -50, -60, -70 → `Class_Out`=1, `Max_Score`=-20. This checks the signed compare.
- Scores 0..9 with random 0–3 cycle valid gaps, then immediately a second frame 9..0 → first pulse `Class_Out`=9, `Max_Score`=9; second pulse `Class_Out`=0, `Max_Score`=9; no cycles are lost between frames.
- Four scores, then Frame_Clear asserted together with a valid score of 1000, then ten scores all equal to 3 → no pulse for the aborted frame; the final pulse gives `Class_Out`=0, `Max_Score`=3.
- GlobalReset=0 after six scores, then ten fresh scores with the max at index 7 → no spurious pulse; `Class_Out`=7. Immediately after reset, all outputs read 0.
- With `ARGMAX_INPUT_REG_EN` defined, repeat the first scenario → identical values; `Class_Valid` arrives one cycle later.
